// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C burst-read sequencer.
package i2c_seq_pkg;
  localparam int DEV_ADDR_W  = 7;
  localparam int DATA_ADDR_W = 8;

  localparam int DEF_BURST_MAX      = 16;
  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_GAP_CYCLES     = 1000;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_DONE, CAPTURE, GAP, FINISH
  } seq_state_e;

  typedef struct packed {
    logic [DEV_ADDR_W-1:0]  dev;
    logic [DATA_ADDR_W-1:0] data;
  } burst_addr_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/i2c_read_sequencer_if.sv
// Sequencer <-> I2C master receiver per-byte command/response bus.
interface i2c_read_sequencer_if;
  import i2c_seq_pkg::*;

  logic                   o_i2c_recv_en;
  logic [DEV_ADDR_W-1:0]  o_device_addr;
  logic [DATA_ADDR_W-1:0] o_data_addr;
  logic [7:0]             i_read_data;
  logic                   i_done_flag;

  modport master (
    output o_i2c_recv_en, o_device_addr, o_data_addr,
    input  i_read_data, i_done_flag
  );

  modport slave (
    input  o_i2c_recv_en, o_device_addr, o_data_addr,
    output i_read_data, i_done_flag
  );
endinterface

// File: rtl/i2c_seq_fifo.sv
// Synchronous show-ahead FIFO: head byte is visible on rdata whenever valid.
module i2c_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_q - rd_q;
  assign valid   = (count != '0);
  assign rdata   = mem[rd_q[AW-1:0]];
  assign do_pop  = pop && valid;
  assign do_push = push && (count != CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + CW'(1);
      if (do_pop)  rd_q <= rd_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/i2c_read_sequencer.sv
// Burst-read sequencer driving the I2C master receiver one byte at a time.
// Optional watchdog on the receiver done flag: define I2C_SEQ_TIMEOUT_EN.
module i2c_read_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int BURST_MAX      = DEF_BURST_MAX,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int LEN_W         = $clog2(BURST_MAX) + 1,
  localparam int FCNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [DEV_ADDR_W-1:0]  i_device_addr,
  input  logic [DATA_ADDR_W-1:0] i_start_addr,
  input  logic [LEN_W-1:0]       i_burst_len,
  output logic                   o_busy,
  output logic                   o_burst_done,
  output logic                   o_err_timeout,
  i2c_read_sequencer_if.master   rx,
  output logic [7:0]             o_fifo_rdata,
  output logic                   o_fifo_valid,
  input  logic                   i_fifo_ready,
  output logic [FCNT_W-1:0]      o_fifo_count
);
  localparam int CNT_W = $clog2(max_int(GAP_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(BURST_MAX);

  seq_state_e       state, state_nxt;
  burst_addr_t      addr_q;
  logic [LEN_W-1:0] rem_q, len_clamped;
  logic [CNT_W-1:0] cnt_q;
  logic             push, has_space, timeout_hit, start_acc;

  assign len_clamped = (i_burst_len > LEN_MAX) ? LEN_MAX : i_burst_len;
  assign start_acc   = (state == IDLE) && i_start;
  // Room is reserved before each byte is requested, so CAPTURE never meets a full FIFO.
  assign has_space   = (o_fifo_count < FCNT_W'(FIFO_DEPTH));

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic err_q;

  assign timeout_hit   = (state == WAIT_DONE) && !rx.i_done_flag && (cnt_q == TO_LAST);
  assign o_err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (rst)              err_q <= 1'b0;
    else if (start_acc)   err_q <= 1'b0;
    else if (timeout_hit) err_q <= 1'b1;
  end
`else
  assign timeout_hit   = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  // Enable stays up through CAPTURE so the receiver holds read data until it is pushed.
  assign rx.o_i2c_recv_en = ((state == ISSUE) && has_space) ||
                            (state == WAIT_DONE) || (state == CAPTURE);
  assign rx.o_device_addr = addr_q.dev;
  assign rx.o_data_addr   = addr_q.data;
  assign o_busy           = (state != IDLE);
  assign o_burst_done     = (state == FINISH);
  assign push             = (state == CAPTURE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (i_start) state_nxt = (len_clamped == '0) ? FINISH : ISSUE;
      ISSUE:     if (has_space) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (rx.i_done_flag)   state_nxt = CAPTURE;
        else if (timeout_hit) state_nxt = GAP;
      end
      CAPTURE:   state_nxt = GAP;
      // GAP lasts GAP_CYCLES+1 clocks of done low, giving that enable-low spacing.
      GAP:       if (!rx.i_done_flag && (cnt_q == GAP_LAST))
                   state_nxt = (rem_q == '0) ? FINISH : ISSUE;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_nxt;

      if ((state != state_nxt) || ((state == GAP) && rx.i_done_flag))
        cnt_q <= '0;
      else if ((state == WAIT_DONE) || (state == GAP))
        cnt_q <= cnt_q + CNT_W'(1);

      case (state)
        IDLE: if (i_start) begin
          addr_q <= '{dev: i_device_addr, data: i_start_addr};
          rem_q  <= len_clamped;
        end
        CAPTURE: begin
          rem_q       <= rem_q - LEN_W'(1);
          addr_q.data <= addr_q.data + DATA_ADDR_W'(1);
        end
        default: ;
      endcase

      // An aborted byte discards the rest of the burst.
      if (timeout_hit) rem_q <= '0;
    end
  end

  i2c_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (rx.i_read_data),
    .pop   (i_fifo_ready),
    .rdata (o_fifo_rdata),
    .valid (o_fifo_valid),
    .count (o_fifo_count)
  );
endmodule

// File: tb/tb_i2c_read_sequencer.sv
// Directed bench for i2c_read_sequencer with a behavioural receiver model.
module tb_i2c_read_sequencer;
  localparam int GAP  = 20;
  localparam int TMO  = 200;
  localparam int SLAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [6:0] i_device_addr = '0;
  logic [7:0] i_start_addr = '0;
  logic [4:0] i_burst_len = '0;
  logic       o_busy, o_burst_done, o_err_timeout;
  logic [7:0] o_fifo_rdata;
  logic       o_fifo_valid;
  logic       i_fifo_ready = 1'b0;
  logic [3:0] o_fifo_count;

  i2c_read_sequencer_if rx_if();

  i2c_read_sequencer #(
    .BURST_MAX(16), .FIFO_DEPTH(8), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_device_addr(i_device_addr),
    .i_start_addr(i_start_addr), .i_burst_len(i_burst_len), .o_busy(o_busy),
    .o_burst_done(o_burst_done), .o_err_timeout(o_err_timeout), .rx(rx_if),
    .o_fifo_rdata(o_fifo_rdata), .o_fifo_valid(o_fifo_valid),
    .i_fifo_ready(i_fifo_ready), .o_fifo_count(o_fifo_count)
  );

  always #10 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] resp [64];
  logic [7:0] addr_log [64];
  logic [6:0] dev_log = '0;
  int byte_idx = 0, hang_idx = -1, lat = 0;
  int rises = 0, low_run = 0, hi_run = 0, last_low = 0, last_high = 0;
  int bd_cycles = 0, bad_busy = 0;
  logic prev_en = 1'b0, prev_bd = 1'b0, slv_en;

  // Receiver model: answers SLAT+1 clocks after enable rises, drops done when enable falls.
  initial begin : slave
    rx_if.i_done_flag = 1'b0;
    rx_if.i_read_data = '0;
    forever begin
      @(posedge clk); #1;
      slv_en = rx_if.o_i2c_recv_en;
      if (slv_en && !prev_en) begin rises++; last_low = low_run; end
      if (!slv_en && prev_en) last_high = hi_run;
      low_run = slv_en ? 0 : low_run + 1;
      hi_run  = slv_en ? hi_run + 1 : 0;
      if (o_burst_done) bd_cycles++;
      if (prev_bd && o_busy) bad_busy++;
      prev_bd = o_burst_done;
      prev_en = slv_en;
      if (!slv_en) begin
        rx_if.i_done_flag = 1'b0;
        lat = 0;
      end else if (!rx_if.i_done_flag) begin
        if (lat >= SLAT && byte_idx != hang_idx) begin
          rx_if.i_read_data = resp[byte_idx];
          addr_log[byte_idx] = rx_if.o_data_addr;
          dev_log = rx_if.o_device_addr;
          rx_if.i_done_flag = 1'b1;
          byte_idx++;
        end else lat++;
      end
    end
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_burst(input logic [6:0] dev, input logic [7:0] addr, input logic [4:0] len);
    i_device_addr = dev; i_start_addr = addr; i_burst_len = len; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (o_busy && k < budget) begin tick(); k++; end
    chk({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic pop_n(input string tag, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(o_fifo_valid), 32'd1);
      chk({tag, "_rdata"}, 32'(o_fifo_rdata), 32'(resp[base + i]));
      i_fifo_ready = 1'b1;
      tick();
      i_fifo_ready = 1'b0;
    end
  endtask

  int base, r0, bd0;

  initial begin
    for (int i = 0; i < 64; i++) resp[i] = 8'h00;
    repeat (3) tick();
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_en",    32'(rx_if.o_i2c_recv_en), 32'd0);
    chk("rst_bdone", 32'(o_burst_done), 32'd0);
    chk("rst_valid", 32'(o_fifo_valid), 32'd0);
    chk("rst_count", 32'(o_fifo_count), 32'd0);
    chk("rst_daddr", 32'(rx_if.o_data_addr), 32'd0);
    chk("rst_dev",   32'(rx_if.o_device_addr), 32'd0);
    chk("rst_err",   32'(o_err_timeout), 32'd0);
    rst = 1'b0;
    tick();

    // Basic 3-byte burst
    base = byte_idx; bd0 = bd_cycles;
    resp[base] = 8'hA5; resp[base+1] = 8'h3C; resp[base+2] = 8'h81;
    start_burst(7'h50, 8'h10, 5'd3);
    chk("A_busy", 32'(o_busy), 32'd1);
    chk("A_en",   32'(rx_if.o_i2c_recv_en), 32'd1);
    chk("A_dev",  32'(rx_if.o_device_addr), 32'h50);
    chk("A_addr", 32'(rx_if.o_data_addr), 32'h10);
    wait_idle("A", 3 * (GAP + 15) + 50);
    chk("A_bytes", 32'(byte_idx - base), 32'd3);
    chk("A_addr0", 32'(addr_log[base]),   32'h10);
    chk("A_addr1", 32'(addr_log[base+1]), 32'h11);
    chk("A_addr2", 32'(addr_log[base+2]), 32'h12);
    chk("A_devlog", 32'(dev_log), 32'h50);
    chk("A_spacing", 32'(last_low), 32'(GAP + 1));
    chk("A_bdone_cycles", 32'(bd_cycles - bd0), 32'd1);
    chk("A_count", 32'(o_fifo_count), 32'd3);
    pop_n("A", base, 3);
    chk("A_empty", 32'(o_fifo_count), 32'd0);

    // Address wrap 0xFE -> 0xFF -> 0x00
    base = byte_idx;
    resp[base] = 8'h11; resp[base+1] = 8'h22; resp[base+2] = 8'h33;
    start_burst(7'h50, 8'hFE, 5'd3);
    wait_idle("B", 3 * (GAP + 15) + 50);
    chk("B_addr0", 32'(addr_log[base]),   32'hFE);
    chk("B_addr1", 32'(addr_log[base+1]), 32'hFF);
    chk("B_addr2", 32'(addr_log[base+2]), 32'h00);
    pop_n("B", base, 3);

    // FIFO backpressure: 12 bytes, consumer stalled
    base = byte_idx; bd0 = bd_cycles;
    for (int i = 0; i < 12; i++) resp[base+i] = 8'(8'h40 + i);
    start_burst(7'h2A, 8'h00, 5'd12);
    for (int k = 0; k < 8 * (GAP + 15) + 50 && o_fifo_count != 4'd8; k++) tick();
    repeat (3 * GAP) tick();
    chk("C_full_count", 32'(o_fifo_count), 32'd8);
    chk("C_full_bytes", 32'(byte_idx - base), 32'd8);
    chk("C_full_en",    32'(rx_if.o_i2c_recv_en), 32'd0);
    chk("C_full_busy",  32'(o_busy), 32'd1);
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 3 * GAP + 50 && !o_fifo_valid; k++) tick();
      chk("C_pop_valid", 32'(o_fifo_valid), 32'd1);
      chk("C_pop_rdata", 32'(o_fifo_rdata), 32'(8'h40 + i));
      i_fifo_ready = 1'b1;
      tick();
      i_fifo_ready = 1'b0;
    end
    wait_idle("C", 2 * (GAP + 15));
    chk("C_bytes", 32'(byte_idx - base), 32'd12);
    chk("C_bdone_cycles", 32'(bd_cycles - bd0), 32'd1);
    chk("C_empty", 32'(o_fifo_count), 32'd0);

    // Zero-length burst
    r0 = rises;
    start_burst(7'h10, 8'h20, 5'd0);
    chk("D_busy",  32'(o_busy), 32'd1);
    chk("D_bdone", 32'(o_burst_done), 32'd1);
    chk("D_en",    32'(rx_if.o_i2c_recv_en), 32'd0);
    tick();
    chk("D_bdone_off", 32'(o_burst_done), 32'd0);
    chk("D_busy_off",  32'(o_busy), 32'd0);
    chk("D_rises", 32'(rises - r0), 32'd0);
    chk("D_count", 32'(o_fifo_count), 32'd0);

    // Length above BURST_MAX is clamped to 16
    base = byte_idx;
    i_fifo_ready = 1'b1;
    start_burst(7'h51, 8'h00, 5'd31);
    wait_idle("F", 16 * (GAP + 15) + 50);
    i_fifo_ready = 1'b0;
    chk("F_bytes", 32'(byte_idx - base), 32'd16);
    chk("F_addr_end", 32'(rx_if.o_data_addr), 32'h10);
    chk("F_empty", 32'(o_fifo_count), 32'd0);

    // Reset during WAIT_DONE of byte 2; start while busy ignored
    base = byte_idx; r0 = rises;
    hang_idx = base + 1;
    start_burst(7'h22, 8'h30, 5'd4);
    for (int k = 0; k < 2 * (GAP + 15) && rises - r0 < 2; k++) tick();
    repeat (5) tick();
    chk("E_en_wait", 32'(rx_if.o_i2c_recv_en), 32'd1);
    chk("E_count1",  32'(o_fifo_count), 32'd1);
    start_burst(7'h7F, 8'h99, 5'd2);
    chk("E_ign_dev",  32'(rx_if.o_device_addr), 32'h22);
    chk("E_ign_addr", 32'(rx_if.o_data_addr), 32'h31);
    rst = 1'b1;
    tick();
    chk("E_rst_en",    32'(rx_if.o_i2c_recv_en), 32'd0);
    chk("E_rst_busy",  32'(o_busy), 32'd0);
    chk("E_rst_count", 32'(o_fifo_count), 32'd0);
    chk("E_rst_daddr", 32'(rx_if.o_data_addr), 32'd0);
    rst = 1'b0;
    hang_idx = -1;
    repeat (3) tick();

`ifdef I2C_SEQ_TIMEOUT_EN
    // Watchdog abort on byte 2 of 4
    base = byte_idx; bd0 = bd_cycles;
    resp[base] = 8'h5E;
    hang_idx = base + 1;
    start_burst(7'h33, 8'h40, 5'd4);
    wait_idle("T", TMO + 4 * (GAP + 15) + 100);
    chk("T_err",   32'(o_err_timeout), 32'd1);
    chk("T_count", 32'(o_fifo_count), 32'd1);
    chk("T_bytes", 32'(byte_idx - base), 32'd1);
    chk("T_bdone_cycles", 32'(bd_cycles - bd0), 32'd1);
    chk("T_en_high", 32'(last_high), 32'(TMO + 1));
    chk("T_en", 32'(rx_if.o_i2c_recv_en), 32'd0);
    hang_idx = -1;
    pop_n("T", base, 1);
    start_burst(7'h33, 8'h00, 5'd0);
    chk("T_err_clr", 32'(o_err_timeout), 32'd0);
    wait_idle("T2", 10);
`endif

    chk("busy_after_done", 32'(bad_busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
